pgm_z80ram_cpu_bridge: RTL and testbench

Bridges the 68000 bus to the CPU-side byte port of the shared Z80 sound RAM (dual-clock dual-port RAM, 8-bit data, one-cycle registered read). It converts each 68000 bus cycle (AS/UDS/LDS/RW) into one or two sequential byte accesses on the RAM port. It then returns DTACK. Big-endian lane mapping is used: UDS maps to the even byte, LDS to the odd byte. It sits between the 68000 address decoder and RAM port A, in the 68000 clock domain.

---
 rtl/pgm_pkg.sv | 20 ++
 rtl/pgm_z80ram_cpu_bridge.sv | 169 ++++++++++++++++
 tb/tb_pgm_z80ram_cpu_bridge.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pgm_pkg.sv
// rtl/pgm_pkg.sv - shared types and constants for the Z80 RAM CPU bridge
package pgm_pkg;

   // Bridge sequencing states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACC_HI,
      ST_ACC_LO,
      ST_FINISH,
      ST_WAIT,
      ST_ACK
   } bridge_state_t;

   // Byte address LSB for each 68000 data lane (big-endian)
   localparam logic LANE_HI = 1'b0;
   localparam logic LANE_LO = 1'b1;

   localparam int DTACK_EXTRA_W = 4;

endpackage

// File: rtl/pgm_z80ram_cpu_bridge.sv
// rtl/pgm_z80ram_cpu_bridge.sv - 68000 bus to Z80 sound RAM byte port bridge
// Purpose: splits each 68000 bus cycle into one or two byte accesses on the
//    RAM A port and returns DTACK once all strobed bytes are done.
// Ports:
//    clk, rst_n                     clock, asynchronous active-low reset
//    cpu_cs, cpu_as_n, cpu_uds_n,
//    cpu_lds_n, cpu_rw, cpu_addr,
//    cpu_din                        68000 bus cycle inputs
//    cpu_dout, cpu_dtack_n          read data and acknowledge to the 68000
//    ram_addr, ram_we, ram_din      byte request to the RAM
//    ram_dout                       RAM read data, one cycle after ram_addr
module pgm_z80ram_cpu_bridge
   import pgm_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int DTACK_EXTRA = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_cs,
   input  logic                  cpu_as_n,
   input  logic                  cpu_uds_n,
   input  logic                  cpu_lds_n,
   input  logic                  cpu_rw,
   input  logic [ADDR_WIDTH-2:0] cpu_addr,
   input  logic [15:0]           cpu_din,
   output logic [15:0]           cpu_dout,
   output logic                  cpu_dtack_n,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [7:0]            ram_din,
   input  logic [7:0]            ram_dout
);

   // Last WAIT count; only meaningful when DTACK_EXTRA is nonzero
   localparam logic [DTACK_EXTRA_W-1:0] EXTRA_LAST = DTACK_EXTRA_W'(DTACK_EXTRA - 1);

   bridge_state_t             state_q, state_d;
   logic [DTACK_EXTRA_W-1:0]  cnt_q, cnt_d;
   logic                      rw_q, rw_d;
   logic                      lds_q, lds_d;
   logic [ADDR_WIDTH-2:0]     addr_q, addr_d;
   logic [7:0]                din_lo_q, din_lo_d;
   logic                      tag_valid_q, tag_valid_d;
   logic                      tag_lane_q, tag_lane_d;
   logic [15:0]               dout_d;
   logic                      dtack_n_d;
   logic [ADDR_WIDTH-1:0]     ram_addr_d;
   logic                      ram_we_d;
   logic [7:0]                ram_din_d;
   logic                      req;

   assign req = cpu_cs & ~cpu_as_n & (~cpu_uds_n | ~cpu_lds_n);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rw_q        <= 1'b0;
         lds_q       <= 1'b0;
         addr_q      <= '0;
         din_lo_q    <= '0;
         tag_valid_q <= 1'b0;
         tag_lane_q  <= LANE_HI;
         cpu_dout    <= 16'hFFFF;
         cpu_dtack_n <= 1'b1;
         ram_addr    <= '0;
         ram_we      <= 1'b0;
         ram_din     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rw_q        <= rw_d;
         lds_q       <= lds_d;
         addr_q      <= addr_d;
         din_lo_q    <= din_lo_d;
         tag_valid_q <= tag_valid_d;
         tag_lane_q  <= tag_lane_d;
         cpu_dout    <= dout_d;
         cpu_dtack_n <= dtack_n_d;
         ram_addr    <= ram_addr_d;
         ram_we      <= ram_we_d;
         ram_din     <= ram_din_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rw_d       = rw_q;
      lds_d      = lds_q;
      addr_d     = addr_q;
      din_lo_d   = din_lo_q;
      dout_d     = cpu_dout;
      dtack_n_d  = 1'b1;
      ram_addr_d = ram_addr;
      ram_din_d  = ram_din;
      ram_we_d   = 1'b0;

      // A read byte is on the RAM port during ACC_*; its data arrives the
      // cycle after, so the lane tag is delayed one cycle to steer the capture.
      tag_valid_d = rw_q & ((state_q == ST_ACC_HI) | (state_q == ST_ACC_LO));
      tag_lane_d  = (state_q == ST_ACC_LO) ? LANE_LO : LANE_HI;
      if (tag_valid_q) begin
         if (tag_lane_q == LANE_HI) dout_d[15:8] = ram_dout;
         else                       dout_d[7:0]  = ram_dout;
      end

      // RAM request registers are loaded on entry to ACC_* so that the byte
      // is presented for exactly the cycle spent in that state.
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               rw_d     = cpu_rw;
               lds_d    = ~cpu_lds_n;
               addr_d   = cpu_addr;
               din_lo_d = cpu_din[7:0];
               dout_d   = 16'hFFFF;
               ram_we_d = ~cpu_rw;
               if (!cpu_uds_n) begin
                  state_d    = ST_ACC_HI;
                  ram_addr_d = {cpu_addr, LANE_HI};
                  ram_din_d  = cpu_din[15:8];
               end else begin
                  state_d    = ST_ACC_LO;
                  ram_addr_d = {cpu_addr, LANE_LO};
                  ram_din_d  = cpu_din[7:0];
               end
            end
         end
         ST_ACC_HI: begin
            if (cpu_as_n) begin
               state_d = ST_IDLE;
            end else if (lds_q) begin
               state_d    = ST_ACC_LO;
               ram_addr_d = {addr_q, LANE_LO};
               ram_din_d  = din_lo_q;
               ram_we_d   = ~rw_q;
            end else begin
               state_d = ST_FINISH;
            end
         end
         ST_ACC_LO: begin
            state_d = cpu_as_n ? ST_IDLE : ST_FINISH;
         end
         ST_FINISH: begin
            cnt_d = '0;
            if (cpu_as_n)              state_d = ST_IDLE;
            else if (DTACK_EXTRA == 0) state_d = ST_ACK;
            else                       state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cpu_as_n) begin
               state_d = ST_IDLE;
            end else if (cnt_q == EXTRA_LAST) begin
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ACK: begin
            if (cpu_as_n) state_d = ST_IDLE;
            else          dtack_n_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_pgm_z80ram_cpu_bridge.sv
// tb/tb_pgm_z80ram_cpu_bridge.sv - self-checking bench for pgm_z80ram_cpu_bridge
module tb_pgm_z80ram_cpu_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cs0 = 1'b0, cs3 = 1'b0;
   logic        as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
   logic [14:0] addr = '0;
   logic [15:0] din = '0;

   logic [15:0] dout0, dout3, ra0, ra3;
   logic        dtack0, dtack3, we0, we3;
   logic [7:0]  rd0, rd3, rq0, rq3;

   logic [7:0]  mem0 [0:65535];
   logic [7:0]  mem3 [0:65535];
   logic [7:0]  ref0 [0:65535];
   logic [7:0]  ref3 [0:65535];

   int total = 0;
   int bad = 0;
   int wc0 = 0;
   int wc3 = 0;

   always #5 clk = ~clk;

   pgm_z80ram_cpu_bridge #(.ADDR_WIDTH(16), .DTACK_EXTRA(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .cpu_cs(cs0), .cpu_as_n(as_n), .cpu_uds_n(uds_n),
      .cpu_lds_n(lds_n), .cpu_rw(rw), .cpu_addr(addr), .cpu_din(din),
      .cpu_dout(dout0), .cpu_dtack_n(dtack0), .ram_addr(ra0), .ram_we(we0),
      .ram_din(rd0), .ram_dout(rq0));

   pgm_z80ram_cpu_bridge #(.ADDR_WIDTH(16), .DTACK_EXTRA(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .cpu_cs(cs3), .cpu_as_n(as_n), .cpu_uds_n(uds_n),
      .cpu_lds_n(lds_n), .cpu_rw(rw), .cpu_addr(addr), .cpu_din(din),
      .cpu_dout(dout3), .cpu_dtack_n(dtack3), .ram_addr(ra3), .ram_we(we3),
      .ram_din(rd3), .ram_dout(rq3));

   // Byte RAM port with one-cycle registered read
   always @(posedge clk) begin
      if (we0) mem0[ra0] <= rd0;
      rq0 <= mem0[ra0];
      if (we3) mem3[ra3] <= rd3;
      rq3 <= mem3[ra3];
   end

   always @(negedge clk) begin
      if (we0 === 1'b1) wc0++;
      if (we3 === 1'b1) wc3++;
   end

   // Reference model: bus-level rules applied to an abstract byte memory
   function automatic int exp_lat(input bit sel3, input bit u, input bit l);
      return ((u && l) ? 4 : 3) + (sel3 ? 3 : 0);
   endfunction

   task automatic model_write(input bit sel3, input logic [14:0] a, input bit u,
                              input bit l, input logic [15:0] d);
      if (sel3) begin
         if (u) ref3[{a, 1'b0}] = d[15:8];
         if (l) ref3[{a, 1'b1}] = d[7:0];
      end else begin
         if (u) ref0[{a, 1'b0}] = d[15:8];
         if (l) ref0[{a, 1'b1}] = d[7:0];
      end
   endtask

   function automatic logic [15:0] model_read(input bit sel3, input logic [14:0] a,
                                               input bit u, input bit l);
      logic [7:0] hi, lo;
      hi = sel3 ? ref3[{a, 1'b0}] : ref0[{a, 1'b0}];
      lo = sel3 ? ref3[{a, 1'b1}] : ref0[{a, 1'b1}];
      return {u ? hi : 8'hFF, l ? lo : 8'hFF};
   endfunction

   // Runs one complete bus cycle; lat counts edges after the sampling edge E
   task automatic bus_access(input bit sel3, input bit r, input logic [14:0] a,
                             input bit u, input bit l, input logic [15:0] d,
                             input int hold, output int lat, output logic [15:0] dv,
                             output int wes, output bit held_ok, output logic rel);
      int w_start;
      @(negedge clk);
      cs0 = !sel3; cs3 = sel3; as_n = 1'b0; uds_n = !u; lds_n = !l;
      rw = r; addr = a; din = d;
      @(posedge clk); #1;
      w_start = sel3 ? wc3 : wc0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if ((sel3 ? dtack3 : dtack0) == 1'b0) begin
            lat = k;
            break;
         end
      end
      dv = sel3 ? dout3 : dout0;
      held_ok = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         if ((sel3 ? dtack3 : dtack0) !== 1'b0) held_ok = 1'b0;
         if ((sel3 ? dout3 : dout0) !== dv) held_ok = 1'b0;
      end
      @(negedge clk);
      as_n = 1'b1; cs0 = 1'b0; cs3 = 1'b0; uds_n = 1'b1; lds_n = 1'b1;
      @(posedge clk); #1;
      rel = sel3 ? dtack3 : dtack0;
      wes = (sel3 ? wc3 : wc0) - w_start;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      total++;
      if ({dtack0, dout0, we0, ra0, rd0} !== {1'b1, 16'hFFFF, 1'b0, 16'h0, 8'h0}) begin
         bad++;
         $display("FAIL reset_dut0 got dtack=%b dout=%h we=%b addr=%h din=%h want 1 ffff 0 0000 00",
                  dtack0, dout0, we0, ra0, rd0);
      end
      total++;
      if ({dtack3, dout3, we3, ra3, rd3} !== {1'b1, 16'hFFFF, 1'b0, 16'h0, 8'h0}) begin
         bad++;
         $display("FAIL reset_dut3 got dtack=%b dout=%h we=%b addr=%h din=%h want 1 ffff 0 0000 00",
                  dtack3, dout3, we3, ra3, rd3);
      end
   endtask

   task automatic test_word_write();
      int lat, wes; logic [15:0] dv; bit h; logic rel;
      bus_access(0, 0, 15'h0100, 1, 1, 16'h1234, 0, lat, dv, wes, h, rel);
      model_write(0, 15'h0100, 1, 1, 16'h1234);
      total++;
      if (mem0[16'h0200] !== 8'h12 || mem0[16'h0201] !== 8'h34) begin
         bad++;
         $display("FAIL word_write_data got %h%h want 1234", mem0[16'h0200], mem0[16'h0201]);
      end
      total++;
      if (lat != 4) begin bad++; $display("FAIL word_write_lat got %0d want 4", lat); end
      total++;
      if (wes != 2) begin bad++; $display("FAIL word_write_we got %0d want 2", wes); end
   endtask

   task automatic test_word_read();
      int lat, wes; logic [15:0] dv; bit h; logic rel;
      bus_access(0, 0, 15'h0100, 1, 1, 16'hABCD, 0, lat, dv, wes, h, rel);
      model_write(0, 15'h0100, 1, 1, 16'hABCD);
      bus_access(0, 1, 15'h0100, 1, 1, 16'h0000, 3, lat, dv, wes, h, rel);
      total++;
      if (dv !== model_read(0, 15'h0100, 1, 1)) begin
         bad++; $display("FAIL word_read_data got %h want %h", dv, model_read(0, 15'h0100, 1, 1));
      end
      total++;
      if (lat != exp_lat(0, 1, 1)) begin bad++; $display("FAIL word_read_lat got %0d want 4", lat); end
      total++;
      if (wes != 0) begin bad++; $display("FAIL word_read_we got %0d want 0", wes); end
      total++;
      if (!h || rel !== 1'b1) begin
         bad++; $display("FAIL word_read_hold got held=%0b rel=%b want 1 1", h, rel);
      end
      bus_access(0, 1, 15'h0100, 0, 1, 16'h0000, 0, lat, dv, wes, h, rel);
      total++;
      if (dv !== 16'hFFCD) begin bad++; $display("FAIL lds_read_data got %h want ffcd", dv); end
      total++;
      if (lat != 3) begin bad++; $display("FAIL lds_read_lat got %0d want 3", lat); end
   endtask

   task automatic test_uds_write();
      int lat, wes; logic [15:0] dv; bit h; logic rel;
      bus_access(0, 0, 15'h0010, 1, 1, 16'h7788, 0, lat, dv, wes, h, rel);
      model_write(0, 15'h0010, 1, 1, 16'h7788);
      bus_access(0, 0, 15'h0010, 1, 0, 16'h5A00, 0, lat, dv, wes, h, rel);
      model_write(0, 15'h0010, 1, 0, 16'h5A00);
      total++;
      if (mem0[16'h0020] !== 8'h5A || mem0[16'h0021] !== 8'h88) begin
         bad++;
         $display("FAIL uds_write_data got %h %h want 5a 88", mem0[16'h0020], mem0[16'h0021]);
      end
      total++;
      if (wes != 1 || lat != 3) begin
         bad++; $display("FAIL uds_write_we_lat got we=%0d lat=%0d want 1 3", wes, lat);
      end
   endtask

   task automatic test_dtack_extra();
      int lat, wes; logic [15:0] dv; bit h; logic rel;
      bus_access(1, 0, 15'h0020, 1, 1, 16'hBEEF, 0, lat, dv, wes, h, rel);
      model_write(1, 15'h0020, 1, 1, 16'hBEEF);
      total++;
      if (lat != 7 || wes != 2) begin
         bad++; $display("FAIL extra_write got lat=%0d we=%0d want 7 2", lat, wes);
      end
      bus_access(1, 1, 15'h0020, 1, 1, 16'h0000, 5, lat, dv, wes, h, rel);
      total++;
      if (lat != 7) begin bad++; $display("FAIL extra_read_lat got %0d want 7", lat); end
      total++;
      if (dv !== model_read(1, 15'h0020, 1, 1)) begin
         bad++; $display("FAIL extra_read_data got %h want beef", dv);
      end
      total++;
      if (!h || rel !== 1'b1) begin
         bad++; $display("FAIL extra_hold_release got held=%0b rel=%b want 1 1", h, rel);
      end
   endtask

   task automatic test_no_request();
      int w_start; bit seen;
      @(negedge clk);
      cs0 = 1'b1; as_n = 1'b1; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b0; din = 16'hFFFF;
      @(posedge clk); #1;
      w_start = wc0; seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (dtack0 !== 1'b1) seen = 1'b1;
      end
      total++;
      if (seen || wc0 != w_start) begin
         bad++; $display("FAIL no_request got dtack_seen=%0b we=%0d want 0 0", seen, wc0 - w_start);
      end
      @(negedge clk);
      cs0 = 1'b0; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
   endtask

   task automatic test_abort();
      int lat, wes, w_start; logic [15:0] dv; bit h, seen; logic rel;
      bus_access(0, 0, 15'h0300, 1, 1, 16'h1111, 0, lat, dv, wes, h, rel);
      model_write(0, 15'h0300, 1, 1, 16'h1111);
      @(negedge clk);
      cs0 = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b0;
      addr = 15'h0300; din = 16'hA5C3;
      @(posedge clk); #1;
      w_start = wc0;
      @(negedge clk);
      as_n = 1'b1; cs0 = 1'b0; uds_n = 1'b1; lds_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (dtack0 !== 1'b1) seen = 1'b1;
      end
      model_write(0, 15'h0300, 1, 0, 16'hA5C3);
      total++;
      if (seen) begin bad++; $display("FAIL abort_dtack got asserted want never"); end
      total++;
      if (wc0 - w_start != 1) begin bad++; $display("FAIL abort_we got %0d want 1", wc0 - w_start); end
      total++;
      if (mem0[16'h0600] !== 8'hA5 || mem0[16'h0601] !== 8'h11) begin
         bad++; $display("FAIL abort_data got %h %h want a5 11", mem0[16'h0600], mem0[16'h0601]);
      end
      bus_access(0, 1, 15'h0300, 1, 1, 16'h0000, 0, lat, dv, wes, h, rel);
      total++;
      if (lat != 4 || dv !== model_read(0, 15'h0300, 1, 1)) begin
         bad++; $display("FAIL abort_next got lat=%0d dout=%h want 4 a511", lat, dv);
      end
   endtask

   task automatic test_reset_mid();
      int lat, wes; logic [15:0] dv; bit h; logic rel;
      @(negedge clk);
      cs0 = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b0;
      addr = 15'h0310; din = 16'h9876;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({dtack0, dout0, we0, ra0, rd0} !== {1'b1, 16'hFFFF, 1'b0, 16'h0, 8'h0}) begin
         bad++;
         $display("FAIL reset_mid got dtack=%b dout=%h we=%b addr=%h din=%h want 1 ffff 0 0000 00",
                  dtack0, dout0, we0, ra0, rd0);
      end
      @(negedge clk);
      as_n = 1'b1; cs0 = 1'b0; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
      rst_n = 1'b1;
      total++;
      if (mem0[16'h0620] !== 8'h98) begin
         bad++; $display("FAIL reset_mid_hi got %h want 98", mem0[16'h0620]);
      end
      bus_access(0, 1, 15'h0310, 1, 1, 16'h0000, 0, lat, dv, wes, h, rel);
      total++;
      if (lat != 4 || dv[15:8] !== 8'h98) begin
         bad++; $display("FAIL reset_mid_read got lat=%0d hi=%h want 4 98", lat, dv[15:8]);
      end
   endtask

   task automatic test_random();
      int lat, wes, errs; logic [15:0] dv, ev; bit h; logic rel;
      bit sel, r, u, l; logic [1:0] s; logic [14:0] a; logic [15:0] d;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 2; j++) begin
            d = 16'($urandom);
            bus_access(j[0], 0, 15'h0040 + 15'(i), 1, 1, d, 0, lat, dv, wes, h, rel);
            model_write(j[0], 15'h0040 + 15'(i), 1, 1, d);
         end
      end
      for (int i = 0; i < 60; i++) begin
         sel = 1'($urandom_range(0, 1));
         r   = 1'($urandom_range(0, 1));
         s   = 2'($urandom_range(1, 3));
         u   = s[1];
         l   = s[0];
         a   = 15'h0040 + 15'($urandom_range(0, 15));
         d   = 16'($urandom);
         bus_access(sel, r, a, u, l, d, $urandom_range(0, 2), lat, dv, wes, h, rel);
         total++;
         if (lat != exp_lat(sel, u, l) || rel !== 1'b1 || !h) begin
            bad++;
            $display("FAIL rand_timing[%0d] got lat=%0d rel=%b held=%0b want %0d 1 1",
                     i, lat, rel, h, exp_lat(sel, u, l));
         end
         if (r) begin
            ev = model_read(sel, a, u, l);
            total++;
            if (dv !== ev || wes != 0) begin
               bad++; $display("FAIL rand_read[%0d] got %h we=%0d want %h 0", i, dv, wes, ev);
            end
         end else begin
            model_write(sel, a, u, l, d);
            total++;
            if (wes != int'(u) + int'(l)) begin
               bad++; $display("FAIL rand_we[%0d] got %0d want %0d", i, wes, int'(u) + int'(l));
            end
         end
      end
      errs = 0;
      for (int b = 16'h0080; b < 16'h00A0; b++) begin
         if (mem0[b] !== ref0[b]) errs++;
         if (mem3[b] !== ref3[b]) errs++;
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL rand_mem got %0d wrong bytes want 0", errs); end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_word_write();
      test_word_read();
      test_uds_write();
      test_dtack_extra();
      test_no_request();
      test_abort();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
